// File: rtl/uc_seq_if.sv
// Control bus between uc_seq and the single-cycle datapath: opcode/z go up,
// selects and write enables come back down in the same cycle.
interface uc_seq_if;
  logic [5:0] opcode;
  logic       z;
  logic       s_inc;
  logic       s_ret;
  logic       s_rre;
  logic       s_inm;
  logic       we3;
  logic       wez;
  logic [2:0] op;

  modport master (
    input  opcode, z,
    output s_inc, s_ret, s_rre, s_inm, we3, wez, op
  );

  modport slave (
    output opcode, z,
    input  s_inc, s_ret, s_rre, s_inm, we3, wez, op
  );
endinterface

// File: rtl/uc_seq.sv
// Microcontroller control unit: combinational decode (zero latency), state updates on
// the retiring edge; no backpressure, the datapath consumes one instruction per cycle.
module uc_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  uc_seq_if.master         ctl,
  output logic             halted,
  output logic             err_nest,
  output logic             err_ret,
  output logic             err_illegal,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t           state, state_nxt;
  logic             call_open, call_nxt;
  logic             nest_nxt, ret_nxt, ill_nxt;
  logic [CNT_W-1:0] instr_nxt, taken_nxt;
  logic             taken, illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      call_open   <= 1'b0;
      err_nest    <= 1'b0;
      err_ret     <= 1'b0;
      err_illegal <= 1'b0;
      instr_cnt   <= '0;
      taken_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      call_open   <= call_nxt;
      err_nest    <= nest_nxt;
      err_ret     <= ret_nxt;
      err_illegal <= ill_nxt;
      instr_cnt   <= instr_nxt;
      taken_cnt   <= taken_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    call_nxt  = call_open;
    nest_nxt  = err_nest;
    ret_nxt   = err_ret;
    ill_nxt   = err_illegal;
    instr_nxt = instr_cnt;
    taken_nxt = taken_cnt;
    taken     = 1'b0;
    illegal   = 1'b0;
    ctl.s_inc = 1'b1;
    ctl.s_ret = 1'b0;
    ctl.s_rre = 1'b0;
    ctl.s_inm = 1'b0;
    ctl.we3   = 1'b0;
    ctl.wez   = 1'b0;
    ctl.op    = 3'b000;

    // Reset keeps the safe defaults; HALTED pins the PC on the HALT's self-address.
    if (!reset) begin
      if (state == HALTED) begin
        ctl.s_inc = 1'b0;
      end else begin
        casez (ctl.opcode)
          6'b1?????: begin
            ctl.op  = ctl.opcode[4:2];
            ctl.we3 = 1'b1;
            ctl.wez = 1'b1;
          end
          6'b0000??: begin
            ctl.s_inm = 1'b1;
            ctl.we3   = 1'b1;
          end
          6'b010000: begin
            ctl.s_inc = 1'b0;
            taken     = 1'b1;
          end
          6'b010001: begin
            ctl.s_inc = ~ctl.z;
            taken     = ctl.z;
          end
          6'b010010: begin
            ctl.s_inc = ctl.z;
            taken     = ~ctl.z;
          end
          6'b010011: begin
            ctl.s_inc = 1'b0;
            ctl.s_rre = 1'b1;
            taken     = 1'b1;
            nest_nxt  = err_nest | call_open;
            call_nxt  = 1'b1;
          end
          6'b010100: begin
            ctl.s_ret = 1'b1;
            taken     = 1'b1;
            ret_nxt   = err_ret | ~call_open;
            call_nxt  = 1'b0;
          end
          6'b010101: begin
            ctl.s_inc = 1'b0;
            state_nxt = HALTED;
          end
          default: illegal = 1'b1;
        endcase

        instr_nxt = instr_cnt + CNT_W'(1);
        if (taken)   taken_nxt = taken_cnt + CNT_W'(1);
        if (illegal) ill_nxt   = 1'b1;
      end
    end
  end

  assign halted = (state == HALTED);

endmodule

// File: tb/tb_uc_seq.sv
module tb_uc_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uc_seq_if cif();
  uc_seq_if wif();

  logic        halted, err_nest, err_ret, err_illegal;
  logic [15:0] instr_cnt, taken_cnt;
  logic        w_halted, w_nest, w_ret, w_ill;
  logic [3:0]  w_instr, w_taken;

  uc_seq dut (
    .clk(clk), .reset(rst), .ctl(cif),
    .halted(halted), .err_nest(err_nest), .err_ret(err_ret), .err_illegal(err_illegal),
    .instr_cnt(instr_cnt), .taken_cnt(taken_cnt)
  );

  uc_seq #(.CNT_W(4)) dut_w (
    .clk(clk), .reset(rst), .ctl(wif),
    .halted(w_halted), .err_nest(w_nest), .err_ret(w_ret), .err_illegal(w_ill),
    .instr_cnt(w_instr), .taken_cnt(w_taken)
  );

  wire [8:0]  ctrl_act = {cif.s_inc, cif.s_ret, cif.s_rre, cif.s_inm, cif.we3, cif.wez, cif.op};
  wire [35:0] stat_act = {halted, err_nest, err_ret, err_illegal, instr_cnt, taken_cnt};

  int total = 0;
  int bad   = 0;

  // Reference model: architectural state as plain integers and flags.
  bit m_halted, m_call, m_nest, m_ret, m_ill;
  int m_instr, m_taken;

  task automatic mreset();
    m_halted = 0; m_call = 0; m_nest = 0; m_ret = 0; m_ill = 0;
    m_instr = 0; m_taken = 0;
  endtask

  task automatic mstep(input int o, input bit zv);
    if (rst || m_halted) return;
    m_instr = (m_instr + 1) % 65536;
    if (o == 16 || o == 19 || o == 20 || (o == 17 && zv) || (o == 18 && !zv))
      m_taken = (m_taken + 1) % 65536;
    if ((o >= 4 && o < 16) || (o >= 22 && o < 32)) m_ill = 1;
    if (o == 19) begin
      if (m_call) m_nest = 1;
      m_call = 1;
    end
    if (o == 20) begin
      if (!m_call) m_ret = 1;
      m_call = 0;
    end
    if (o == 21) m_halted = 1;
  endtask

  function automatic logic [8:0] exp_ctrl(input int o, input bit zv);
    bit si = 1, sr = 0, rr = 0, im = 0, w3 = 0, wz = 0;
    logic [2:0] alu = 3'b000;
    if (!rst && m_halted) si = 0;
    else if (!rst) begin
      if (o >= 32) begin alu = 3'((o / 4) % 8); w3 = 1; wz = 1; end
      else if (o < 4) begin im = 1; w3 = 1; end
      else if (o == 16) si = 0;
      else if (o == 17) si = !zv;
      else if (o == 18) si = zv;
      else if (o == 19) begin si = 0; rr = 1; end
      else if (o == 20) sr = 1;
      else if (o == 21) si = 0;
    end
    return {si, sr, rr, im, w3, wz, alu};
  endfunction

  function automatic logic [35:0] exp_stat();
    return {m_halted, m_nest, m_ret, m_ill, 16'(m_instr), 16'(m_taken)};
  endfunction

  task automatic drive(input int o, input bit zv);
    @(negedge clk);
    rst = 1'b0;
    cif.opcode = 6'(o);
    cif.z = zv;
    #2;
  endtask

  task automatic retire(input int o, input bit zv);
    @(posedge clk);
    #1;
    mstep(o, zv);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mreset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    cif.opcode = 6'b101011;
    cif.z = 1'b1;
    #2;
    total++;
    if (ctrl_act !== 9'b1_00000_000) begin
      bad++; $display("FAIL reset_ctrl act=%b exp=%b", ctrl_act, 9'b1_00000_000);
    end
    @(posedge clk);
    #1;
    mreset();
    total++;
    if (stat_act !== 36'd0) begin
      bad++; $display("FAIL reset_state act=%h exp=0", stat_act);
    end
  endtask

  task automatic test_alu();
    int ops[6] = '{43, 32, 63, 0, 3, 50};
    do_reset();
    foreach (ops[i]) begin
      drive(ops[i], 1'b0);
      total++;
      if (ctrl_act !== exp_ctrl(ops[i], 1'b0)) begin
        bad++; $display("FAIL alu_ctrl op=%0d act=%b exp=%b", ops[i], ctrl_act, exp_ctrl(ops[i], 1'b0));
      end
      if (i == 0) begin
        total++;
        if (cif.op !== 3'b010 || cif.we3 !== 1'b1 || cif.wez !== 1'b1) begin
          bad++; $display("FAIL alu_101011 op=%b we3=%b wez=%b exp op=010 we3=1 wez=1", cif.op, cif.we3, cif.wez);
        end
      end
      retire(ops[i], 1'b0);
      if (i == 0) begin
        total++;
        if (instr_cnt !== 16'd1 || taken_cnt !== 16'd0) begin
          bad++; $display("FAIL alu_counts instr=%0d taken=%0d exp 1/0", instr_cnt, taken_cnt);
        end
      end
      total++;
      if (stat_act !== exp_stat()) begin
        bad++; $display("FAIL alu_state act=%h exp=%h", stat_act, exp_stat());
      end
    end
  endtask

  task automatic test_jumps();
    int ops[6] = '{17, 17, 18, 18, 16, 17};
    bit zs[6]  = '{0, 1, 0, 1, 0, 1};
    do_reset();
    foreach (ops[i]) begin
      drive(ops[i], zs[i]);
      total++;
      if (ctrl_act !== exp_ctrl(ops[i], zs[i])) begin
        bad++; $display("FAIL jump_ctrl op=%0d z=%0d act=%b exp=%b", ops[i], zs[i], ctrl_act, exp_ctrl(ops[i], zs[i]));
      end
      retire(ops[i], zs[i]);
      total++;
      if (stat_act !== exp_stat()) begin
        bad++; $display("FAIL jump_state op=%0d act=%h exp=%h", ops[i], stat_act, exp_stat());
      end
    end
    total++;
    if (taken_cnt !== 16'd4) begin
      bad++; $display("FAIL jump_taken act=%0d exp=4", taken_cnt);
    end
  endtask

  task automatic test_call();
    int ops[13] = '{19, 20, 20, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    do_reset();
    foreach (ops[i]) begin
      drive(ops[i], 1'b0);
      total++;
      if (ctrl_act !== exp_ctrl(ops[i], 1'b0)) begin
        bad++; $display("FAIL call_ctrl op=%0d act=%b exp=%b", ops[i], ctrl_act, exp_ctrl(ops[i], 1'b0));
      end
      retire(ops[i], 1'b0);
      if (i == 1) begin
        total++;
        if (err_ret !== 1'b0 || err_nest !== 1'b0 || taken_cnt !== 16'd2) begin
          bad++; $display("FAIL call_pair nest=%b ret=%b taken=%0d exp 0/0/2", err_nest, err_ret, taken_cnt);
        end
      end
      total++;
      if (stat_act !== exp_stat()) begin
        bad++; $display("FAIL call_state act=%h exp=%h", stat_act, exp_stat());
      end
    end
    total++;
    if (err_ret !== 1'b1) begin
      bad++; $display("FAIL call_sticky_ret act=%b exp=1", err_ret);
    end
  endtask

  task automatic test_nest();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(19, 1'b0);
      total++;
      if (cif.s_rre !== 1'b1 || cif.s_inc !== 1'b0) begin
        bad++; $display("FAIL nest_ctrl s_rre=%b s_inc=%b exp 1/0", cif.s_rre, cif.s_inc);
      end
      retire(19, 1'b0);
    end
    total++;
    if (err_nest !== 1'b1 || stat_act !== exp_stat()) begin
      bad++; $display("FAIL nest_state act=%h exp=%h", stat_act, exp_stat());
    end
  endtask

  task automatic test_halt();
    int ops[6] = '{2, 21, 43, 19, 17, 20};
    do_reset();
    foreach (ops[i]) begin
      drive(ops[i], 1'b1);
      total++;
      if (ctrl_act !== exp_ctrl(ops[i], 1'b1)) begin
        bad++; $display("FAIL halt_ctrl op=%0d act=%b exp=%b", ops[i], ctrl_act, exp_ctrl(ops[i], 1'b1));
      end
      if (i == 1) begin
        total++;
        if (cif.s_inc !== 1'b0 || cif.we3 !== 1'b0 || halted !== 1'b0) begin
          bad++; $display("FAIL halt_cycle s_inc=%b we3=%b halted=%b exp 0/0/0", cif.s_inc, cif.we3, halted);
        end
      end
      retire(ops[i], 1'b1);
      total++;
      if (stat_act !== exp_stat()) begin
        bad++; $display("FAIL halt_state act=%h exp=%h", stat_act, exp_stat());
      end
    end
    total++;
    if (halted !== 1'b1 || instr_cnt !== 16'd2) begin
      bad++; $display("FAIL halt_frozen halted=%b instr=%0d exp 1/2", halted, instr_cnt);
    end
    do_reset();
    total++;
    if (stat_act !== 36'd0) begin
      bad++; $display("FAIL halt_reset act=%h exp=0", stat_act);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    rst = 1'b0;
    wif.opcode = 6'b010001;
    wif.z = 1'b0;
    cif.opcode = 6'b010001;
    cif.z = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    total++;
    if (w_instr !== 4'd1 || w_ill !== 1'b0) begin
      bad++; $display("FAIL wrap_cnt instr=%0d ill=%b exp 1/0", w_instr, w_ill);
    end
    @(negedge clk);
    wif.opcode = 6'b000100;
    #2;
    total++;
    if (wif.we3 !== 1'b0 || wif.s_inc !== 1'b1) begin
      bad++; $display("FAIL illegal_ctrl we3=%b s_inc=%b exp 0/1", wif.we3, wif.s_inc);
    end
    @(posedge clk);
    #1;
    total++;
    if (w_ill !== 1'b1) begin
      bad++; $display("FAIL illegal_flag act=%b exp=1", w_ill);
    end
  endtask

  task automatic test_random();
    int o, r;
    bit zv;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4 || (m_halted && r < 15)) begin
        do_reset();
        total++;
        if (stat_act !== 36'd0) begin
          bad++; $display("FAIL rand_reset act=%h exp=0", stat_act);
        end
        continue;
      end
      if (r < 7) o = 21;
      else if (r < 40) o = 16 + $urandom_range(0, 4);
      else begin
        o = $urandom_range(0, 63);
        if (o == 21) o = 20;
      end
      zv = 1'($urandom_range(0, 1));
      drive(o, zv);
      total++;
      if (ctrl_act !== exp_ctrl(o, zv)) begin
        bad++; $display("FAIL rand_ctrl op=%0d z=%0d act=%b exp=%b", o, zv, ctrl_act, exp_ctrl(o, zv));
      end
      retire(o, zv);
      total++;
      if (stat_act !== exp_stat()) begin
        bad++; $display("FAIL rand_state op=%0d act=%h exp=%h", o, stat_act, exp_stat());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    cif.opcode = 6'b0;
    cif.z = 1'b0;
    wif.opcode = 6'b010001;
    wif.z = 1'b0;
    mreset();
    test_reset();
    test_alu();
    test_jumps();
    test_call();
    test_nest();
    test_halt();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
